// File: rtl/tl_a_fragment_gen.sv
// tl_a_fragment_gen: splits a TileLink A request larger than 2^MAX_LG_SIZE bytes
// into a train of 2^MAX_LG_SIZE-byte fragments with incrementing addresses.
// Data-less requests (Get/Hint) are expanded by holding them in the upstream
// repeater through do_repeat, which drives the repeater's io_repeat input.
// Data-carrying requests arrive one beat per fragment and pass beat-for-beat.
// `repeat` is a reserved word, so that port is named do_repeat.
// Optional macro TL_FRAG_ASSERT_EN compiles in simulation-only input checks.
module tl_a_fragment_gen #(
   parameter int unsigned ADDR_W      = 15,
   parameter int unsigned SOURCE_W    = 8,
   parameter int unsigned MASK_W      = 8,
   parameter int unsigned MAX_LG_SIZE = 3,
   parameter int unsigned FRAG_W      = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_opcode,
   input  logic [2:0]          in_param,
   input  logic [2:0]          in_size,
   input  logic [SOURCE_W-1:0] in_source,
   input  logic [ADDR_W-1:0]   in_address,
   input  logic [MASK_W-1:0]   in_mask,
   input  logic                in_corrupt,
   output logic                do_repeat,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2:0]          out_opcode,
   output logic [2:0]          out_param,
   output logic [2:0]          out_size,
   output logic [SOURCE_W-1:0] out_source,
   output logic [ADDR_W-1:0]   out_address,
   output logic [MASK_W-1:0]   out_mask,
   output logic                out_corrupt,
   output logic [FRAG_W-1:0]   out_frag,
   output logic                busy
);

   logic [FRAG_W-1:0] remaining_q, remaining_d;
   logic              busy_q, busy_d;
   logic [FRAG_W-1:0] total, cur, idx;
   logic              dataless, fire, big;

   // Fragment bookkeeping derived from the presented request
   always_comb begin
      dataless = (in_opcode == 3'd4) || (in_opcode == 3'd5);
      big      = in_size > 3'(MAX_LG_SIZE);
      total    = '0;
      if (big) begin
         total = FRAG_W'((32'd1 << (32'(in_size) - MAX_LG_SIZE)) - 32'd1);
      end
      cur  = busy_q ? remaining_q : total;
      idx  = total - cur;
      fire = in_valid && out_ready;
   end

   // State register: fragments remaining and train-in-progress flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         remaining_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
      end
   end

   // Next state: advance on each fired fragment, clear after the last one
   always_comb begin
      remaining_d = remaining_q;
      busy_d      = busy_q;
      if (fire) begin
         if (cur != '0) begin
            remaining_d = cur - 1'b1;
            busy_d      = 1'b1;
         end else begin
            remaining_d = '0;
            busy_d      = 1'b0;
         end
      end
   end

   // Outputs: zero-latency handshake and per-fragment fields
   always_comb begin
      out_valid   = in_valid;
      in_ready    = dataless ? (out_ready && (cur == '0)) : out_ready;
      do_repeat   = dataless && (cur != '0);
      out_opcode  = in_opcode;
      out_param   = in_param;
      out_size    = big ? 3'(MAX_LG_SIZE) : in_size;
      out_source  = in_source;
      // Base is aligned to the full request size, so OR places the fragment offset
      out_address = in_address | (ADDR_W'(idx) << MAX_LG_SIZE);
      out_mask    = in_mask;
      out_corrupt = in_corrupt;
      out_frag    = cur;
      busy        = busy_q;
   end

`ifdef TL_FRAG_ASSERT_EN
   logic                prev_valid_q;
   logic [2:0]          prev_opcode_q, prev_param_q, prev_size_q;
   logic [SOURCE_W-1:0] prev_source_q;
   logic [ADDR_W-1:0]   prev_address_q;
   logic [MASK_W-1:0]   prev_mask_q;
   logic                prev_corrupt_q;
   logic [ADDR_W-1:0]   align_mask;

   // Previous-cycle input snapshot used to detect fields changing mid-train
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_valid_q   <= 1'b0;
         prev_opcode_q  <= '0;
         prev_param_q   <= '0;
         prev_size_q    <= '0;
         prev_source_q  <= '0;
         prev_address_q <= '0;
         prev_mask_q    <= '0;
         prev_corrupt_q <= 1'b0;
      end else begin
         prev_valid_q   <= in_valid;
         prev_opcode_q  <= in_opcode;
         prev_param_q   <= in_param;
         prev_size_q    <= in_size;
         prev_source_q  <= in_source;
         prev_address_q <= in_address;
         prev_mask_q    <= in_mask;
         prev_corrupt_q <= in_corrupt;
      end
   end

   // Low address bits that must be zero for a naturally aligned request
   always_comb begin
      align_mask = ADDR_W'((32'd1 << in_size) - 32'd1);
   end

   // Simulation-only protocol checks on the repeater side
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (in_valid) begin
            assert ((in_address & align_mask) == '0)
            else $error("tl_a_fragment_gen: address %0h not aligned to size %0d",
                        in_address, in_size);
         end
         if (busy_q && in_valid && prev_valid_q) begin
            assert (in_opcode == prev_opcode_q && in_param == prev_param_q &&
                    in_size == prev_size_q && in_source == prev_source_q &&
                    in_address == prev_address_q && in_mask == prev_mask_q &&
                    in_corrupt == prev_corrupt_q)
            else $error("tl_a_fragment_gen: input field changed during a train");
         end
         if (busy_q) begin
            assert (in_valid)
            else $error("tl_a_fragment_gen: in_valid dropped during a train");
         end
      end
   end
`endif

endmodule

// File: tb/tb_tl_a_fragment_gen.sv
// Self-checking bench for tl_a_fragment_gen: a per-request fragment counter model
// checked every cycle, directed scenarios with literal expectations, then
// randomized requests with random downstream back-pressure.
module tb_tl_a_fragment_gen;
   localparam int ADDR_W = 15;
   localparam int SOURCE_W = 8;
   localparam int MASK_W = 8;

   logic                clock, reset;
   logic                in_valid, in_ready;
   logic [2:0]          in_opcode, in_param, in_size;
   logic [SOURCE_W-1:0] in_source;
   logic [ADDR_W-1:0]   in_address;
   logic [MASK_W-1:0]   in_mask;
   logic                in_corrupt;
   logic                do_repeat, out_valid, out_ready;
   logic [2:0]          out_opcode, out_param, out_size;
   logic [SOURCE_W-1:0] out_source;
   logic [ADDR_W-1:0]   out_address;
   logic [MASK_W-1:0]   out_mask;
   logic                out_corrupt;
   logic [3:0]          out_frag;
   logic                busy;

   int tests = 0;
   int fails = 0;
   int k = 0; // fragments already fired for the current request

   tl_a_fragment_gen dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_param(in_param), .in_size(in_size), .in_source(in_source),
      .in_address(in_address), .in_mask(in_mask), .in_corrupt(in_corrupt),
      .do_repeat(do_repeat), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_param(out_param), .out_size(out_size),
      .out_source(out_source), .out_address(out_address), .out_mask(out_mask),
      .out_corrupt(out_corrupt), .out_frag(out_frag), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: a request of 2^size bytes is n = 2^(size-3) fragments (min 1);
   // fragment k sits at base + 8k with n-1-k fragments left after it.
   always @(negedge clock) begin
      int n, frag;
      logic dl;
      if (reset) k = 0;
      n    = (in_size > 3) ? (1 << (in_size - 3)) : 1;
      frag = n - 1 - k;
      dl   = (in_opcode == 3'd4) || (in_opcode == 3'd5);
      check("out_valid", 32'(out_valid), 32'(in_valid));
      check("busy", 32'(busy), 32'(k != 0));
      check("out_frag", 32'(out_frag), 32'(frag));
      check("out_address", 32'(out_address), 32'(in_address) + 32'(k * 8));
      check("out_size", 32'(out_size), (in_size > 3) ? 32'd3 : 32'(in_size));
      check("repeat", 32'(do_repeat), 32'(dl && frag != 0));
      check("in_ready", 32'(in_ready), dl ? 32'(out_ready && frag == 0) : 32'(out_ready));
      check("out_fields", {out_opcode, out_param, out_source, out_mask, out_corrupt},
            {in_opcode, in_param, in_source, in_mask, in_corrupt});
      if (!reset && in_valid && out_ready) k = (frag == 0) ? 0 : k + 1;
   end

   task automatic set_req(input logic [2:0] op, input logic [2:0] sz, input logic [14:0] addr);
      in_valid   = 1'b1;
      in_opcode  = op;
      in_size    = sz;
      in_address = addr;
      in_param   = 3'($urandom);
      in_source  = 8'($urandom);
      in_mask    = 8'($urandom);
      in_corrupt = 1'($urandom);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Present one request until all its fragments have fired (bounded)
   task automatic run_req(input logic [2:0] op, input logic [2:0] sz, input logic [14:0] addr);
      int n, fired, cycles;
      n = (sz > 3) ? (1 << (sz - 3)) : 1;
      fired = 0;
      cycles = 0;
      set_req(op, sz, addr);
      out_ready = ($urandom_range(0, 3) != 0);
      while (fired < n && cycles < 300) begin
         @(posedge clock);
         if (out_ready) fired++;
         cycles++;
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
      check("req_complete", 32'(fired), 32'(n));
      in_valid = 1'b0;
   endtask

   initial begin
      logic [14:0] exp_a [4];
      logic [14:0] am, addr;
      logic [2:0]  sz;
      exp_a = '{15'h040, 15'h048, 15'h050, 15'h058};
      reset = 1'b1;
      in_valid = 1'b0; in_opcode = 3'd4; in_param = '0; in_size = '0;
      in_source = '0; in_address = '0; in_mask = '0; in_corrupt = 1'b0;
      out_ready = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_repeat", 32'(do_repeat), 32'd0);
      check("rst_frag", 32'(out_frag), 32'd0);
      step(); step();
      reset = 1'b0;

      // Get size 5 at 0x40, always ready
      set_req(3'd4, 3'd5, 15'h040);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("get5_addr", 32'(out_address), 32'(exp_a[i]));
         check("get5_frag", 32'(out_frag), 32'(3 - i));
         check("get5_size", 32'(out_size), 32'd3);
         check("get5_repeat", 32'(do_repeat), (i < 3) ? 32'd1 : 32'd0);
         check("get5_in_ready", 32'(in_ready), (i == 3) ? 32'd1 : 32'd0);
         step();
      end
      in_valid = 1'b0;
      check("get5_busy_after", 32'(busy), 32'd0);

      // Get size 2 at 0x104: single fragment
      set_req(3'd4, 3'd2, 15'h104);
      @(negedge clock);
      check("get2_addr", 32'(out_address), 32'h104);
      check("get2_size", 32'(out_size), 32'd2);
      check("get2_frag", 32'(out_frag), 32'd0);
      check("get2_repeat", 32'(do_repeat), 32'd0);
      step();
      check("get2_busy", 32'(busy), 32'd0);
      in_valid = 1'b0;

      // PutFull size 4 at 0x200: two beats
      set_req(3'd0, 3'd4, 15'h200);
      @(negedge clock);
      check("put_addr0", 32'(out_address), 32'h200);
      check("put_frag0", 32'(out_frag), 32'd1);
      check("put_ready0", 32'(in_ready), 32'd1);
      check("put_repeat0", 32'(do_repeat), 32'd0);
      step();
      @(negedge clock);
      check("put_addr1", 32'(out_address), 32'h208);
      check("put_frag1", 32'(out_frag), 32'd0);
      check("put_ready1", 32'(in_ready), 32'd1);
      step();
      check("put_busy", 32'(busy), 32'd0);
      in_valid = 1'b0;

      // Get size 4 at 0x310 with a 3-cycle stall after the first fire
      set_req(3'd4, 3'd4, 15'h310);
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("stall_addr", 32'(out_address), 32'h318);
         check("stall_frag", 32'(out_frag), 32'd0);
         check("stall_busy", 32'(busy), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      @(negedge clock);
      check("stall_done_ready", 32'(in_ready), 32'd1);
      step();
      check("stall_busy_after", 32'(busy), 32'd0);
      in_valid = 1'b0;

      // Get size 6 at 0x400, reset after the 2nd fragment
      set_req(3'd4, 3'd6, 15'h400);
      step(); step();
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1; in_valid = 1'b0; in_size = 3'd0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_repeat", 32'(do_repeat), 32'd0);
      step();
      reset = 1'b0;
      set_req(3'd4, 3'd6, 15'h400);
      @(negedge clock);
      check("restart_frag", 32'(out_frag), 32'd7);
      check("restart_addr", 32'(out_address), 32'h400);
      for (int i = 0; i < 8; i++) step();
      check("restart_busy_after", 32'(busy), 32'd0);
      in_valid = 1'b0;

      // Randomized requests with random back-pressure and idle gaps
      for (int r = 0; r < 150; r++) begin
         sz   = 3'($urandom_range(0, 7));
         am   = 15'((32'd1 << sz) - 32'd1);
         addr = 15'($urandom) & ~am;
         run_req(3'($urandom_range(0, 5)), sz, addr);
         repeat ($urandom_range(0, 2)) begin
            out_ready = 1'($urandom);
            step();
         end
      end

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
